ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_pkg.sv | 29 ++
 rtl/ex_mem_stage_hilo_reg.sv | 25 ++
 rtl/ex_mem_stage.sv | 121 ++++++++++++
 tb/tb_ex_mem_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared CPU definitions: HI/LO op encoding, datapath widths and the EX/MEM payload.
package ex_mem_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PC_W      = 30;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned HILO_OP_W = 2;
    localparam int unsigned MULT_W    = 2 * XLEN;

    typedef enum logic [HILO_OP_W-1:0] {
        HILO_NONE = 2'b00,
        HILO_MULT = 2'b01,
        HILO_MTHI = 2'b10,
        HILO_MTLO = 2'b11
    } hilo_op_e;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [XLEN-1:0]   alure;
        logic [XLEN-1:0]   bus_b;
        logic [REG_W-1:0]  rd;
        logic              reg_wr;
        logic              mem_wr;
        logic              mem_to_reg;
        logic              mem_read;
    } mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_hilo_reg.sv
// HI/LO special registers with independent write enables and synchronous clear.
module hilo_reg
    import ex_mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we_hi,
    input  logic            we_lo,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    output logic [XLEN-1:0] hi_num,
    output logic [XLEN-1:0] lo_num
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_num <= '0;
            lo_num <= '0;
        end else begin
            if (we_hi) hi_num <= hi_in;
            if (we_lo) lo_num <= lo_in;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with bubble insertion, stall hold and HI/LO update.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:2]          EX_PC,
    input  logic [XLEN-1:0]      EX_alure,
    input  logic [XLEN-1:0]      EX_busA,
    input  logic [XLEN-1:0]      EX_busB,
    input  logic [REG_W-1:0]     EX_Reg,
    input  logic                 EX_RegWr,
    input  logic                 EX_MemWr,
    input  logic                 EX_MemtoReg,
    input  logic                 EX_MemRead,
    input  logic [HILO_OP_W-1:0] EX_hilo_op,
    input  logic [MULT_W-1:0]    EX_MULT_result,
    output logic                 Mem_valid,
    output logic [PC_W-1:0]      Mem_PC,
    output logic [XLEN-1:0]      Mem_alure,
    output logic [XLEN-1:0]      Mem_busB,
    output logic [REG_W-1:0]     Mem_Reg,
    output logic                 Mem_RegWr,
    output logic                 Mem_MemWr,
    output logic                 Mem_MemtoReg,
    output logic                 Mem_MemRead,
    output logic [XLEN-1:0]      hi_num,
    output logic [XLEN-1:0]      lo_num,
    output logic                 Mem_load_pending
);

    mem_payload_t    mem_q;
    mem_payload_t    capt_c;
    logic            advance_c;
    logic            we_hi_c;
    logic            we_lo_c;
    logic [XLEN-1:0] hi_in_c;
    logic [XLEN-1:0] lo_in_c;

    assign advance_c = !stall && !flush;

    // Sanitised EX payload; a flush keeps the data fields but kills all side effects.
    always_comb begin
        capt_c            = '0;
        capt_c.valid      = 1'b1;
        capt_c.pc         = EX_PC;
        capt_c.alure      = EX_alure;
        capt_c.bus_b      = EX_busB;
        capt_c.rd         = EX_Reg;
        capt_c.reg_wr     = EX_RegWr && (EX_Reg != REG_W'(0));
        capt_c.mem_wr     = EX_MemWr && !EX_MemRead;
        capt_c.mem_to_reg = EX_MemtoReg;
        capt_c.mem_read   = EX_MemRead;
        if (flush) begin
            capt_c.valid      = 1'b0;
            capt_c.rd         = '0;
            capt_c.reg_wr     = 1'b0;
            capt_c.mem_wr     = 1'b0;
            capt_c.mem_to_reg = 1'b0;
            capt_c.mem_read   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (!stall) begin
            mem_q <= capt_c;
        end
    end

    // HI/LO writes commit on the same edge the instruction leaves EX.
    always_comb begin
        we_hi_c = 1'b0;
        we_lo_c = 1'b0;
        hi_in_c = EX_MULT_result[MULT_W-1:XLEN];
        lo_in_c = EX_MULT_result[XLEN-1:0];
        if (advance_c) begin
            unique case (hilo_op_e'(EX_hilo_op))
                HILO_MULT: begin
                    we_hi_c = 1'b1;
                    we_lo_c = 1'b1;
                end
                HILO_MTHI: begin
                    we_hi_c = 1'b1;
                    hi_in_c = EX_busA;
                end
                HILO_MTLO: begin
                    we_lo_c = 1'b1;
                    lo_in_c = EX_busA;
                end
                default: ;
            endcase
        end
    end

    hilo_reg u_hilo_reg (
        .clk    (clk),
        .rst    (rst),
        .we_hi  (we_hi_c),
        .we_lo  (we_lo_c),
        .hi_in  (hi_in_c),
        .lo_in  (lo_in_c),
        .hi_num (hi_num),
        .lo_num (lo_num)
    );

    assign Mem_valid        = mem_q.valid;
    assign Mem_PC           = mem_q.pc;
    assign Mem_alure        = mem_q.alure;
    assign Mem_busB         = mem_q.bus_b;
    assign Mem_Reg          = mem_q.rd;
    assign Mem_RegWr        = mem_q.reg_wr;
    assign Mem_MemWr        = mem_q.mem_wr;
    assign Mem_MemtoReg     = mem_q.mem_to_reg;
    assign Mem_MemRead      = mem_q.mem_read;
    assign Mem_load_pending = mem_q.valid && mem_q.mem_read;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push expectations, a negedge monitor checks.
module tb_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:2] EX_PC;
    logic [31:0] EX_alure;
    logic [31:0] EX_busA;
    logic [31:0] EX_busB;
    logic [4:0]  EX_Reg;
    logic        EX_RegWr;
    logic        EX_MemWr;
    logic        EX_MemtoReg;
    logic        EX_MemRead;
    logic [1:0]  EX_hilo_op;
    logic [63:0] EX_MULT_result;
    logic        Mem_valid;
    logic [29:0] Mem_PC;
    logic [31:0] Mem_alure;
    logic [31:0] Mem_busB;
    logic [4:0]  Mem_Reg;
    logic        Mem_RegWr;
    logic        Mem_MemWr;
    logic        Mem_MemtoReg;
    logic        Mem_MemRead;
    logic [31:0] hi_num;
    logic [31:0] lo_num;
    logic        Mem_load_pending;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        bit          chk_data;
        logic        valid;
        logic [29:0] pc;
        logic [31:0] alure;
        logic [31:0] busb;
        logic [4:0]  rd;
        logic        regwr;
        logic        memwr;
        logic        memtoreg;
        logic        memread;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        lp;
    } exp_t;

    exp_t exp_q[$];

    ex_mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .EX_PC            (EX_PC),
        .EX_alure         (EX_alure),
        .EX_busA          (EX_busA),
        .EX_busB          (EX_busB),
        .EX_Reg           (EX_Reg),
        .EX_RegWr         (EX_RegWr),
        .EX_MemWr         (EX_MemWr),
        .EX_MemtoReg      (EX_MemtoReg),
        .EX_MemRead       (EX_MemRead),
        .EX_hilo_op       (EX_hilo_op),
        .EX_MULT_result   (EX_MULT_result),
        .Mem_valid        (Mem_valid),
        .Mem_PC           (Mem_PC),
        .Mem_alure        (Mem_alure),
        .Mem_busB         (Mem_busB),
        .Mem_Reg          (Mem_Reg),
        .Mem_RegWr        (Mem_RegWr),
        .Mem_MemWr        (Mem_MemWr),
        .Mem_MemtoReg     (Mem_MemtoReg),
        .Mem_MemRead      (Mem_MemRead),
        .hi_num           (hi_num),
        .lo_num           (lo_num),
        .Mem_load_pending (Mem_load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(string name, bit chk_data, logic valid, logic [29:0] pc,
                                logic [31:0] alure, logic [31:0] busb, logic [4:0] rd,
                                logic regwr, logic memwr, logic memtoreg, logic memread,
                                logic [31:0] hi, logic [31:0] lo, logic lp);
        exp_t e;
        e.name = name;  e.chk_data = chk_data; e.valid = valid; e.pc = pc;
        e.alure = alure; e.busb = busb; e.rd = rd; e.regwr = regwr; e.memwr = memwr;
        e.memtoreg = memtoreg; e.memread = memread; e.hi = hi; e.lo = lo; e.lp = lp;
        return e;
    endfunction

    task automatic chk(input string name, input string field, input logic [63:0] act,
                       input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, one expectation per clock.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "valid",    64'(Mem_valid),        64'(e.valid));
            chk(e.name, "reg",      64'(Mem_Reg),          64'(e.rd));
            chk(e.name, "regwr",    64'(Mem_RegWr),        64'(e.regwr));
            chk(e.name, "memwr",    64'(Mem_MemWr),        64'(e.memwr));
            chk(e.name, "memtoreg", 64'(Mem_MemtoReg),     64'(e.memtoreg));
            chk(e.name, "memread",  64'(Mem_MemRead),      64'(e.memread));
            chk(e.name, "hi",       64'(hi_num),           64'(e.hi));
            chk(e.name, "lo",       64'(lo_num),           64'(e.lo));
            chk(e.name, "loadpend", 64'(Mem_load_pending), 64'(e.lp));
            if (e.chk_data) begin
                chk(e.name, "pc",    64'(Mem_PC),    64'(e.pc));
                chk(e.name, "alure", 64'(Mem_alure), 64'(e.alure));
                chk(e.name, "busb",  64'(Mem_busB),  64'(e.busb));
            end
        end
    end

    task automatic clr_ex();
        EX_PC = '0; EX_alure = '0; EX_busA = '0; EX_busB = '0; EX_Reg = '0;
        EX_RegWr = 1'b0; EX_MemWr = 1'b0; EX_MemtoReg = 1'b0; EX_MemRead = 1'b0;
        EX_hilo_op = 2'b00; EX_MULT_result = '0;
    endtask

    task automatic tick(input exp_t e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        clr_ex();

        // Reset
        tick(mk("reset", 1, 0, 30'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        rst = 1'b0;

        // Basic capture
        EX_PC = 30'h100; EX_alure = 32'h0000_1234; EX_busB = 32'hAAAA; EX_Reg = 5'd5; EX_RegWr = 1'b1;
        tick(mk("capture", 1, 1, 30'h100, 32'h1234, 32'hAAAA, 5'd5, 1, 0, 0, 0, 32'h0, 32'h0, 0));

        // Instr A: a load, then three stalled cycles with changing inputs
        clr_ex();
        EX_PC = 30'h200; EX_alure = 32'hA0A0; EX_busB = 32'hB0B0; EX_Reg = 5'd7;
        EX_RegWr = 1'b1; EX_MemtoReg = 1'b1; EX_MemRead = 1'b1;
        tick(mk("instrA", 1, 1, 30'h200, 32'hA0A0, 32'hB0B0, 5'd7, 1, 0, 1, 1, 32'h0, 32'h0, 1));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            EX_PC = 30'h280 + 30'(i); EX_alure = 32'hFFFF_0000 + 32'(i); EX_Reg = 5'd20 + 5'(i);
            EX_MemRead = 1'b0; EX_MemWr = 1'b1; EX_hilo_op = 2'b01;
            EX_MULT_result = 64'h1111_2222_3333_4444; EX_busA = 32'h99;
            flush = (i == 1);
            tick(mk("stall", 1, 1, 30'h200, 32'hA0A0, 32'hB0B0, 5'd7, 1, 0, 1, 1, 32'h0, 32'h0, 1));
        end
        stall = 1'b0; flush = 1'b0;

        // Flushed MULT must not touch HI/LO; the same MULT unflushed must
        clr_ex();
        EX_PC = 30'h300; EX_alure = 32'h33; EX_busB = 32'h44; EX_Reg = 5'd9; EX_RegWr = 1'b1;
        EX_hilo_op = 2'b01; EX_MULT_result = 64'hDEAD_BEEF_0000_0001;
        flush = 1'b1;
        tick(mk("flush_mult", 0, 0, 30'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        flush = 1'b0;
        tick(mk("mult", 1, 1, 30'h300, 32'h33, 32'h44, 5'd9, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h1, 0));

        // Back-to-back MTHI / MTLO
        clr_ex();
        EX_PC = 30'h400; EX_hilo_op = 2'b10; EX_busA = 32'h11;
        tick(mk("mthi", 1, 1, 30'h400, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h11, 32'h1, 0));
        EX_PC = 30'h401; EX_hilo_op = 2'b11; EX_busA = 32'h22;
        tick(mk("mtlo", 1, 1, 30'h401, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h11, 32'h22, 0));

        // Register 0 write suppression
        clr_ex();
        EX_PC = 30'h500; EX_alure = 32'h55; EX_Reg = 5'd0; EX_RegWr = 1'b1;
        tick(mk("reg0", 1, 1, 30'h500, 32'h55, 32'h0, 5'd0, 0, 0, 0, 0, 32'h11, 32'h22, 0));

        // Read and write both asserted: read wins
        clr_ex();
        EX_PC = 30'h501; EX_alure = 32'h66; EX_busB = 32'h77; EX_Reg = 5'd3;
        EX_RegWr = 1'b1; EX_MemtoReg = 1'b1; EX_MemRead = 1'b1; EX_MemWr = 1'b1;
        tick(mk("rd_wr", 1, 1, 30'h501, 32'h66, 32'h77, 5'd3, 1, 0, 1, 1, 32'h11, 32'h22, 1));

        // Plain store
        clr_ex();
        EX_PC = 30'h502; EX_alure = 32'h88; EX_busB = 32'hCAFE_F00D; EX_MemWr = 1'b1;
        tick(mk("store", 1, 1, 30'h502, 32'h88, 32'hCAFE_F00D, 5'd0, 0, 1, 0, 0, 32'h11, 32'h22, 0));

        // Load held by stall, then reset with stall/flush and a pending MULT
        clr_ex();
        EX_PC = 30'h600; EX_alure = 32'h1000; EX_Reg = 5'd4; EX_RegWr = 1'b1; EX_MemRead = 1'b1;
        tick(mk("load", 1, 1, 30'h600, 32'h1000, 32'h0, 5'd4, 1, 0, 0, 1, 32'h11, 32'h22, 1));
        stall = 1'b1;
        tick(mk("load_hold", 1, 1, 30'h600, 32'h1000, 32'h0, 5'd4, 1, 0, 0, 1, 32'h11, 32'h22, 1));
        rst = 1'b1; flush = 1'b1; EX_hilo_op = 2'b01; EX_MULT_result = 64'h5555_6666_7777_8888;
        tick(mk("rst_mid", 1, 0, 30'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        // First edge after reset captures normally
        clr_ex();
        EX_PC = 30'h3FFF_FFFF; EX_alure = 32'hFFFF_FFFF; EX_busB = 32'h1; EX_Reg = 5'd31; EX_RegWr = 1'b1;
        EX_hilo_op = 2'b01; EX_MULT_result = 64'h0000_0002_8000_0000;
        tick(mk("resume", 1, 1, 30'h3FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 5'd31, 1, 0, 0, 0, 32'h2, 32'h8000_0000, 0));

        clr_ex();
        begin : drain
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL drain pending=%0d required=0", exp_q.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
